// File: rtl/seg_595_dyn_scan.sv
// Scans DIGITS 7-segment digits through a 74HC595 chain, one {sel,seg} word per dwell period.
// Outputs are registered decodes of scan state; upd is always accepted, blank only gates oe.
module seg_595_dyn_scan #(
  parameter int DIGITS      = 6,
  parameter int SHCP_HALF   = 2,
  parameter int DWELL_MAX   = 49_999,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   point_in,
  input  logic [DIGITS-1:0]   en_in,
  input  logic                lzb_in,
  input  logic                upd,
  input  logic                blank,
  output logic                ds,
  output logic                shcp,
  output logic                stcp,
  output logic                oe,
  output logic                frame_start
);

  localparam int N      = DIGITS + 8;
  localparam int PERIOD = 2 * SHCP_HALF;
  localparam int PW     = $clog2(PERIOD) + 1;
  localparam int DW     = $clog2(DWELL_MAX + 1) + 1;
  localparam int BW     = $clog2(N) + 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_HIGH   = PW'(SHCP_HALF);
  localparam logic [PW-1:0] LT_LAST   = PW'(SHCP_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL_MAX);
  localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   point;
    logic [DIGITS-1:0]   en;
    logic                lzb;
  } disp_t;

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [PW-1:0]   phase, phase_nxt;
  logic [N-1:0]    sr, sr_nxt, sw_load;
  disp_t           in_rec, shadow, active, src;
  logic            done, done_nxt;
  logic            ds_d, shcp_d, stcp_d, oe_d, fs_d;
  logic [3:0]      nib;
  logic            upper_zero, dig_off;
  logic [7:0]      seg_on, seg;
  logic [DIGITS-1:0] sel;

  assign in_rec = {data_in, point_in, en_in, lzb_in};

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  // Digit 0 LOAD sees an upd arriving in the same cycle, so that frame already uses it.
  always_comb begin
    src = active;
    if (idx == 3'd0) src = upd ? in_rec : shadow;
  end

  always_comb begin
    nib        = src.data[{idx, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j > int'(idx) && src.data[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    dig_off = !src.en[idx] || (src.lzb && nib == 4'h0 && upper_zero && idx != 3'd0);
    seg_on  = dig_off ? 8'h00 : {src.point[idx], font(nib)};
    seg     = SEG_ACT_LOW ? ~seg_on : seg_on;
    sel     = DIGITS'(1) << idx;
    if (SEL_ACT_LOW) sel = ~sel;
    sw_load = {sel, seg};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      idx         <= '0;
      dwell       <= '0;
      bit_cnt     <= '0;
      phase       <= '0;
      sr          <= '0;
      shadow      <= '0;
      active      <= '0;
      done        <= 1'b0;
      ds          <= 1'b0;
      shcp        <= 1'b0;
      stcp        <= 1'b0;
      oe          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      dwell       <= dwell_nxt;
      bit_cnt     <= bit_nxt;
      phase       <= phase_nxt;
      sr          <= sr_nxt;
      done        <= done_nxt;
      ds          <= ds_d;
      shcp        <= shcp_d;
      stcp        <= stcp_d;
      oe          <= oe_d;
      frame_start <= fs_d;
      if (upd) shadow <= in_rec;
      if (state == LOAD && idx == 3'd0) active <= src;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell + 1'b1;
    bit_nxt   = bit_cnt;
    phase_nxt = phase;
    sr_nxt    = sr;
    case (state)
      IDLE: begin
        state_nxt = LOAD;
        dwell_nxt = '0;
      end
      LOAD: begin
        state_nxt = SHIFT;
        sr_nxt    = sw_load;
        bit_nxt   = '0;
        phase_nxt = '0;
      end
      SHIFT: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          sr_nxt    = sr >> 1;
          if (bit_cnt == BIT_LAST) state_nxt = LATCH;
          else                     bit_nxt   = bit_cnt + 1'b1;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LATCH: begin
        if (phase == LT_LAST) begin
          state_nxt = HOLD;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      HOLD: begin
        if (dwell == DWELL_END) begin
          state_nxt = LOAD;
          dwell_nxt = '0;
          idx_nxt   = (idx == IDX_LAST) ? 3'd0 : idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoding the next state lets every output come straight from a flop.
  always_comb begin
    ds_d     = (state_nxt == SHIFT) && sr_nxt[0];
    shcp_d   = (state_nxt == SHIFT) && (phase_nxt >= PH_HIGH);
    stcp_d   = (state_nxt == LATCH);
    fs_d     = (state_nxt == LOAD) && (idx_nxt == 3'd0);
    done_nxt = done || (state == LATCH && state_nxt == HOLD);
    oe_d     = done_nxt ? blank : 1'b1;
  end

endmodule
